// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, baud divisor helper and
// the frame data width common to the transmitter and receiver.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous RX line plus an edge register.
// All flops reset to 1 so that an idle line never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_in,
    output logic rx_sync,
    output logic fall_edge
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            sync_p2 <= 1'b1;
        end else begin
            sync_p0 <= rx_in;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign rx_sync   = sync_p1;
    assign fall_edge = sync_p2 & ~sync_p1;

endmodule

// File: rtl/one_byte_uart_rx.sv
// Single-byte 8N1 UART receiver, LSB first, mid-bit sampling on the system clock.
// Optional parity check (PARITY state, PARITY_ODD selects odd) under UART_RX_PARITY_EN.
module one_byte_uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy,
    output logic                 rx_parity_err
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);
    localparam int HALF_DIV = BAUD_DIV / 2;
    localparam int CNT_W    = $clog2(BAUD_DIV);
    localparam int BIT_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic rx_sync;
    logic fall_edge;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_in     (rx_in),
        .rx_sync   (rx_sync),
        .fall_edge (fall_edge)
    );

    rx_state_t            state;
    rx_state_t            state_n;
    logic [CNT_W-1:0]     baud_cnt;
    logic [CNT_W-1:0]     baud_n;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_n;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n;
    logic                 ferr_n;
    logic                 baud_last;

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_n;
    logic perr_n;
    logic par_bad;

    assign par_bad = ((^shift_reg) ^ par_bit) != PARITY_ODD[0];
`endif

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign rx_busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            baud_cnt     <= '0;
            bit_cnt      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            baud_cnt     <= baud_n;
            bit_cnt      <= bit_n;
            rx_data      <= data_n;
            rx_valid     <= valid_n;
            rx_frame_err <= ferr_n;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= perr_n;
`endif
        end
    end

    // Shift register and parity sample are pure data; they are only read after being filled.
    always_ff @(posedge clk) begin
        shift_reg <= shift_n;
`ifdef UART_RX_PARITY_EN
        par_bit   <= par_n;
`endif
    end

    always_comb begin
        state_n = state;
        baud_n  = baud_last ? '0 : baud_cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_bit;
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                baud_n = '0;
                bit_n  = '0;
                if (fall_edge) begin
                    state_n = START;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    shift_n = {rx_sync, shift_reg[DATA_BITS-1:1]};
                    bit_n   = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    par_n   = rx_sync;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                // Leave at mid-stop so a start bit right after the stop bit is still seen.
                if (baud_last) begin
                    state_n = IDLE;
                    baud_n  = '0;
                    if (!rx_sync) begin
                        ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        perr_n = 1'b1;
`endif
                    end else begin
                        data_n  = shift_reg;
                        valid_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                baud_n  = '0;
                bit_n   = '0;
            end
        endcase
    end

`ifndef UART_RX_PARITY_EN
    assign rx_parity_err = 1'b0 & PARITY_ODD[0];
`endif

endmodule

// File: tb/tb_one_byte_uart_rx.sv
// Self-checking bench for one_byte_uart_rx: a frame-level model predicts each
// output pulse and the held byte; parity cases run when UART_RX_PARITY_EN is set.
module tb_one_byte_uart_rx;

    localparam int BAUD_DIV = 434;
    localparam int HALF_DIV = 217;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAT_MIN   = 9 * BAUD_DIV + HALF_DIV + PAR * BAUD_DIV;
    localparam int LAT_MAX   = LAT_MIN + 4;
    localparam int FRAME_CLK = (10 + PAR) * BAUD_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
    logic       rx_parity_err;

    one_byte_uart_rx dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx_in         (rx_in),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_err  (rx_frame_err),
        .rx_busy       (rx_busy),
        .rx_parity_err (rx_parity_err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = good byte, 1 = frame error, 2 = parity error
    typedef struct {
        int         kind;
        logic [7:0] data;
        int         start;
    } exp_t;

    exp_t       q[$];
    int         valid_cyc[$];
    logic [7:0] model_data = 8'h00;
    int         checks = 0;
    int         failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, want, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d at cycle %0d", name, act, lo, hi, cyc);
        end
    endtask

    // Every cycle: any pulse must match the oldest pending frame, and rx_data must hold the model byte.
    always @(negedge clk) begin : cmp
        int         age;
        logic [2:0] want;
        logic [2:0] got;
        if (rst_n) begin
            got = {rx_valid, rx_frame_err, rx_parity_err};
            if (got != 3'b000) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", 32'(got), 32'd0);
                end else begin
                    age  = cyc - q[0].start;
                    want = 3'b100 >> q[0].kind;
                    check("pulse_kind", 32'(got), 32'(want));
                    check_range("pulse_latency", age, LAT_MIN, LAT_MAX);
                    if (q[0].kind == 0) begin
                        model_data = q[0].data;
                        valid_cyc.push_back(cyc);
                    end
                    void'(q.pop_front());
                end
            end else if (q.size() > 0 && (cyc - q[0].start) > LAT_MAX) begin
                checks++;
                failures++;
                $display("FAIL missed_pulse kind=%0d data=%0h required by cycle %0d", q[0].kind, q[0].data,
                         q[0].start + LAT_MAX);
                void'(q.pop_front());
            end
            check("rx_data", 32'(rx_data), 32'(model_data));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_time(input logic v);
        rx_in = v;
        idle(BAUD_DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic bad_par);
        exp_t e;
        e.data  = d;
        e.kind  = !stop_bit ? 1 : ((PAR != 0 && bad_par) ? 2 : 0);
        e.start = cyc;
        q.push_back(e);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        if (PAR != 0) bit_time((^d) ^ bad_par);
        bit_time(stop_bit);
    endtask

    initial begin
        int s0;
        int g0;

        idle(5);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_pulses", {29'd0, rx_valid, rx_frame_err, rx_parity_err}, 32'd0);
        check("reset_busy", 32'(rx_busy), 32'd0);
        rst_n = 1'b1;
        idle(20);

        s0 = cyc;
        send_frame(8'hC5, 1'b1, 1'b0);
        idle(50);
        check("first_byte", 32'(rx_data), 32'hC5);
        if (valid_cyc.size() >= 1) check_range("first_latency", valid_cyc[0] - s0, 4123 + PAR * 434, 4127 + PAR * 434);
        else check("first_valid_seen", 32'(valid_cyc.size()), 32'd1);

        send_frame(8'hC5, 1'b1, 1'b0);
        send_frame(8'h6A, 1'b1, 1'b0);
        idle(50);
        check("b2b_second_byte", 32'(rx_data), 32'h6A);
        if (valid_cyc.size() >= 3) check("b2b_spacing", 32'(valid_cyc[2] - valid_cyc[1]), 32'(4340 + PAR * 434));
        else check("b2b_valid_count", 32'(valid_cyc.size()), 32'd3);

        g0 = cyc;
        rx_in = 1'b0;
        idle(50);
        check("glitch_busy_high", 32'(rx_busy), 32'd1);
        idle(50);
        rx_in = 1'b1;
        idle(300 - (cyc - g0));
        check("glitch_busy_low", 32'(rx_busy), 32'd0);
        idle(100);
        send_frame(8'h55, 1'b1, 1'b0);
        idle(50);
        check("after_glitch_byte", 32'(rx_data), 32'h55);

        send_frame(8'hA3, 1'b0, 1'b0);
        idle(2000);
        check("held_low_no_start", 32'(rx_busy), 32'd0);
        check("ferr_keeps_data", 32'(rx_data), 32'h55);
        rx_in = 1'b1;
        idle(1000);
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(50);
        check("after_ferr_byte", 32'(rx_data), 32'h3C);

        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        idle(200);
        check("midframe_busy", 32'(rx_busy), 32'd1);
        rst_n = 1'b0;
        q.delete();
        model_data = 8'h00;
        #1;
        check("midreset_busy", 32'(rx_busy), 32'd0);
        check("midreset_rx_data", 32'(rx_data), 32'h00);
        check("midreset_pulses", {29'd0, rx_valid, rx_frame_err, rx_parity_err}, 32'd0);
        idle(10);
        rst_n = 1'b1;
        idle(500);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(50);
        check("after_reset_byte", 32'(rx_data), 32'h0F);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        idle(50);
        check("parity_good_byte", 32'(rx_data), 32'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(50);
        check("parity_bad_keeps", 32'(rx_data), 32'h07);
`endif

        idle(LAT_MAX);
        check("no_pending_frames", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
